// File: rtl/row_fetch_pkg.sv
// row_fetch_pkg: shared types and constants for the row fetch master
package row_fetch_pkg;
  localparam int FIFO_DEPTH = 2;
  localparam int IDX_W = 4;
  localparam int ROW_W = 64;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [ROW_W-1:0] data;
  } row_entry_t;
endpackage

// File: rtl/row_fetch_master_fifo.sv
// row_fifo2: two-entry synchronous FIFO with flush and combinational head
module row_fifo2
  import row_fetch_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  row_entry_t i_din,
  output row_entry_t o_head,
  output logic [1:0] o_count
);
  row_entry_t r_mem [FIFO_DEPTH];
  logic       r_wp;
  logic       r_rp;
  logic [1:0] r_cnt;
  // storage, pointers and occupancy; flush drops everything at once
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_flush) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= ~r_wp;
      end
      if (i_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;
endmodule

// File: rtl/row_fetch_master.sv
// row_fetch_master: Avalon-MM read master streaming NUM_ROWS rows through a 2-deep FIFO
module row_fetch_master
  import row_fetch_pkg::*;
#(
  parameter int                NUM_ROWS  = 9,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = ROW_W,
  parameter int                TIMEOUT   = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W-1:0] o_avm_address,
  output logic              o_avm_read,
  input  logic [DATA_W-1:0] i_avm_readdata,
  input  logic              i_avm_readdatavalid,
  input  logic              i_avm_waitrequest,
  output logic [DATA_W-1:0] o_row_data,
  output logic [IDX_W-1:0]  o_row_idx,
  output logic              o_row_valid,
  input  logic              i_row_ready
);
  localparam int CNT_W = IDX_W + 1;
  localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ROWS     = CNT_W'(NUM_ROWS);
  localparam logic [CNT_W-1:0] LAST_POP = CNT_W'(NUM_ROWS - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  state_t             r_state;
  logic [CNT_W-1:0]   r_issue_cnt;
  logic [CNT_W-1:0]   r_pop_cnt;
  logic [TO_W-1:0]    r_to;
  logic               r_outstanding;
  logic               r_read;
  logic [ADDR_W-1:0]  r_addr;
  logic [IDX_W-1:0]   r_last_idx;
  logic               w_fetch;
  logic               w_start;
  logic               w_issue;
  logic               w_rsp;
  logic               w_timeout;
  logic               w_pop;
  logic               w_last_pop;
  logic [1:0]         w_count;
  row_entry_t         w_din;
  row_entry_t         w_head;
  assign w_fetch    = r_state == ST_FETCH;
  assign w_start    = i_start && !w_fetch;
  assign w_issue    = w_fetch && !r_outstanding && !i_avm_waitrequest && (r_issue_cnt < ROWS) &&
                      ((w_count + {1'b0, r_outstanding}) < 2'(FIFO_DEPTH));
  assign w_rsp      = w_fetch && r_outstanding && i_avm_readdatavalid;
  assign w_timeout  = w_fetch && r_outstanding && !i_avm_readdatavalid && (r_to == TO_LAST);
  assign w_pop      = o_row_valid && i_row_ready;
  assign w_last_pop = w_pop && (r_pop_cnt == LAST_POP);
  assign w_din      = '{idx: r_last_idx, data: i_avm_readdata};
  row_fifo2 u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_rsp),
    .i_pop   (w_pop),
    .i_flush (w_start || w_timeout),
    .i_din   (w_din),
    .o_head  (w_head),
    .o_count (w_count)
  );
  // run control: issue one read at a time, retire responses, watch for timeout and completion
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_issue_cnt   <= '0;
      r_pop_cnt     <= '0;
      r_to          <= '0;
      r_outstanding <= 1'b0;
      r_read        <= 1'b0;
      r_addr        <= '0;
      r_last_idx    <= '0;
    end else begin
      r_read <= w_issue;
      if (w_start) begin
        r_state       <= ST_FETCH;
        r_issue_cnt   <= '0;
        r_pop_cnt     <= '0;
        r_to          <= '0;
        r_outstanding <= 1'b0;
      end else if (w_fetch) begin
        if (w_issue) begin
          r_outstanding <= 1'b1;
          r_issue_cnt   <= r_issue_cnt + CNT_ONE;
          r_addr        <= BASE_ADDR + ADDR_W'(r_issue_cnt);
          r_last_idx    <= r_issue_cnt[IDX_W-1:0];
          r_to          <= '0;
        end else if (w_rsp) begin
          r_outstanding <= 1'b0;
        end else if (w_timeout) begin
          r_outstanding <= 1'b0;
          r_state       <= ST_ERR;
        end else if (r_outstanding) begin
          r_to <= r_to + TO_ONE;
        end
        if (w_pop) r_pop_cnt <= r_pop_cnt + CNT_ONE;
        if (w_last_pop) r_state <= ST_DONE;
      end
    end
  end
  assign o_busy        = r_state == ST_FETCH;
  assign o_done        = r_state == ST_DONE;
  assign o_error       = r_state == ST_ERR;
  assign o_avm_read    = r_read;
  assign o_avm_address = r_addr;
  assign o_row_valid   = w_count != 2'd0;
  assign o_row_data    = w_head.data;
  assign o_row_idx     = w_head.idx;
endmodule

// File: tb/tb_row_fetch_master.sv
// tb_row_fetch_master: randomized directed bench with a latency slave and ROM reference model
module tb_row_fetch_master;
  localparam int N = 9;
  logic        clk = 0, rst = 0, start = 0, waitreq = 0, ready = 0, s_rdv = 0, spur_rdv = 0;
  logic [63:0] s_data = '0;
  logic        busy, done, error, avm_read, row_valid;
  logic [31:0] addr;
  logic [63:0] row_data;
  logic [3:0]  row_idx;
  logic [63:0] rom [16];
  int          lat = 15, cd = 0, n_reads = 0, multi = 0, n_pass = 0, n_total = 0;
  bit          mute = 0, pend = 0;
  logic [3:0]  paddr;
  logic [31:0] addr_q [$];
  logic [3:0]  idx_q [$];
  logic [63:0] data_q [$];

  always #5 clk = ~clk;

  row_fetch_master dut (
    .i_clk               (clk),
    .i_reset             (rst),
    .i_start             (start),
    .o_busy              (busy),
    .o_done              (done),
    .o_error             (error),
    .o_avm_address       (addr),
    .o_avm_read          (avm_read),
    .i_avm_readdata      (s_data),
    .i_avm_readdatavalid (s_rdv | spur_rdv),
    .i_avm_waitrequest   (waitreq),
    .o_row_data          (row_data),
    .o_row_idx           (row_idx),
    .o_row_valid         (row_valid),
    .i_row_ready         (ready)
  );

  // slave with fixed latency serving the ROM, plus a stream monitor recording accepted rows
  always @(negedge clk) begin
    s_rdv = 0;
    if (rst) pend = 0;
    if (pend) begin
      if (cd <= 1) begin
        s_rdv  = 1;
        s_data = rom[paddr];
        pend   = 0;
      end else cd--;
    end
    if (avm_read) begin
      n_reads++;
      addr_q.push_back(addr);
      if (pend) multi++;
      if (!mute) begin
        pend  = 1;
        cd    = lat;
        paddr = addr[3:0];
      end
    end
    if (row_valid && ready) begin
      idx_q.push_back(row_idx);
      data_q.push_back(row_data);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d checks passed)", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic new_rom;
    for (int i = 0; i < N; i++) rom[i] = {$urandom, $urandom};
  endtask

  task automatic clr;
    addr_q.delete();
    idx_q.delete();
    data_q.delete();
    n_reads = 0;
    multi = 0;
  endtask

  task automatic do_start;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int c = 0;
    while (!done && c < budget) begin
      if (rnd) ready = 1'($urandom);
      tick();
      c++;
    end
    ready = 1;
    check("done_reached", 64'(done), 64'd1);
  endtask

  task automatic check_run(input string tag);
    check({tag, "_nreads"}, 64'(n_reads), 64'd9);
    check({tag, "_npops"}, 64'(idx_q.size()), 64'd9);
    check({tag, "_multi_outstanding"}, 64'(multi), 64'd0);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_valid_end"}, 64'(row_valid), 64'd0);
    if (addr_q.size() == N && idx_q.size() == N)
      for (int i = 0; i < N; i++) begin
        check($sformatf("%s_addr%0d", tag, i), 64'(addr_q[i]), 64'(i));
        check($sformatf("%s_idx%0d", tag, i), 64'(idx_q[i]), 64'(i));
        check($sformatf("%s_data%0d", tag, i), data_q[i], rom[i]);
      end
  endtask

  initial begin
    int c, bad;
    #1 rst = 1;
    #1;
    check("rst_ctrl", 64'({busy, done, error, avm_read, row_valid}), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_row", 64'({row_idx, row_data[59:0]}), 64'd0);
    tick();
    tick();
    rst = 0;
    // nominal run, latency 15, always ready
    new_rom();
    clr();
    lat = 15;
    ready = 1;
    do_start();
    check("lat_busy", 64'(busy), 64'd1);
    check("lat_no_read_yet", 64'(avm_read), 64'd0);
    tick();
    check("lat_first_read", 64'(avm_read), 64'd1);
    check("lat_first_addr", 64'(addr), 64'd0);
    tick();
    check("read_one_cycle", 64'(avm_read), 64'd0);
    wait_done(1000, 0);
    check_run("nominal");
    check("nominal_done", 64'(done), 64'd1);
    // backpressure: only two reads while the consumer stalls
    new_rom();
    clr();
    lat = 3;
    ready = 0;
    do_start();
    repeat (60) tick();
    check("bp_nreads", 64'(n_reads), 64'd2);
    check("bp_addr0", 64'(addr_q[0]), 64'd0);
    check("bp_addr1", 64'(addr_q[1]), 64'd1);
    check("bp_read_idle", 64'(avm_read), 64'd0);
    check("bp_valid", 64'(row_valid), 64'd1);
    check("bp_head_idx", 64'(row_idx), 64'd0);
    check("bp_head_data", row_data, rom[0]);
    ready = 1;
    tick();
    check("bp_pop_no_read", 64'(avm_read), 64'd0);
    check("bp_pop_nreads", 64'(n_reads), 64'd2);
    tick();
    check("bp_third_read", 64'(avm_read), 64'd1);
    check("bp_third_addr", 64'(addr), 64'd2);
    wait_done(1000, 0);
    check_run("bp");
    // timeout: slave never answers
    clr();
    mute = 1;
    do_start();
    c = 0;
    while (!avm_read && c < 50) begin
      tick();
      c++;
    end
    check("to_read_seen", 64'(avm_read), 64'd1);
    bad = 0;
    repeat (63) begin
      tick();
      if (error || !busy) bad++;
    end
    check("to_not_early", 64'(bad), 64'd0);
    tick();
    check("to_error", 64'(error), 64'd1);
    check("to_busy", 64'(busy), 64'd0);
    check("to_valid", 64'(row_valid), 64'd0);
    check("to_read", 64'(avm_read), 64'd0);
    spur_rdv = 1;
    tick();
    spur_rdv = 0;
    tick();
    check("to_late_rdv_ignored", 64'(row_valid), 64'd0);
    check("to_still_error", 64'(error), 64'd1);
    mute = 0;
    new_rom();
    clr();
    lat = $urandom_range(1, 20);
    do_start();
    check("to_restart_clears_error", 64'(error), 64'd0);
    wait_done(1000, 0);
    check_run("to_restart");
    // asynchronous reset mid-run after three pops
    new_rom();
    clr();
    lat = $urandom_range(1, 20);
    do_start();
    c = 0;
    while (idx_q.size() < 3 && c < 500) begin
      tick();
      c++;
    end
    check("mid_three_pops", 64'(idx_q.size()), 64'd3);
    #2 rst = 1;
    #1;
    check("mid_rst_ctrl", 64'({busy, done, error, avm_read, row_valid}), 64'd0);
    check("mid_rst_addr", 64'(addr), 64'd0);
    check("mid_rst_row", 64'({row_idx, row_data[59:0]}), 64'd0);
    tick();
    rst = 0;
    spur_rdv = 1;
    tick();
    spur_rdv = 0;
    tick();
    check("idle_spur_no_push", 64'(row_valid), 64'd0);
    check("idle_spur_busy", 64'(busy), 64'd0);
    new_rom();
    clr();
    do_start();
    wait_done(1000, 0);
    check_run("post_rst");
    // start re-pulsed during fetch under random backpressure
    new_rom();
    clr();
    lat = $urandom_range(8, 20);
    do_start();
    repeat (5) tick();
    start = 1;
    tick();
    start = 0;
    repeat (10) tick();
    start = 1;
    tick();
    start = 0;
    wait_done(3000, 1);
    check_run("restart_ignored");
    spur_rdv = 1;
    tick();
    spur_rdv = 0;
    tick();
    check("done_spur_no_push", 64'(row_valid), 64'd0);
    check("done_sticky", 64'(done), 64'd1);
    // waitrequest held after start
    new_rom();
    clr();
    lat = $urandom_range(1, 20);
    waitreq = 1;
    do_start();
    bad = 0;
    repeat (19) begin
      tick();
      if (avm_read) bad++;
    end
    check("wr_no_read", 64'(bad), 64'd0);
    check("wr_nreads", 64'(n_reads), 64'd0);
    waitreq = 0;
    tick();
    check("wr_read_after_drop", 64'(avm_read), 64'd1);
    check("wr_addr", 64'(addr), 64'd0);
    wait_done(1000, 0);
    check_run("wr");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
